l1_refill_arbiter: RTL and testbench
====================================

// Module: l1_refill_arbiter
// PURPOSE
//  Shares one AXI-style read port between the L1 instruction-cache and L1 data-cache refill engines.
//  Grants one requester per cache-line burst (round-robin) and issues one AR with len=BEATS-1.
//  Steers each R beat back to the granted cache with a per-beat ready strobe.
//  Sits between the L1 caches and the CPU-wrapper AXI master.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  beat / word width
//  BEATS   4   beats per line refill (16-byte line); power of two, >=2
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  ic_req     in   1       I-cache refill request, level, held until ic_done
//  ic_addr    in   ADDR_W  I-cache line address; low log2(BEATS*DATA_W/8) bits ignored
//  ic_rdata   out  DATA_W  beat data to I-cache (valid when ic_ready=1)
//  ic_ready   out  1       one-cycle strobe per beat delivered to I-cache
//  ic_beat    out  2       index of current beat (0..BEATS-1)
//  ic_done    out  1       one-cycle strobe after the last beat
//  dc_req / dc_addr / dc_rdata / dc_ready / dc_beat / dc_done   same as ic_*, D-cache side
//  araddr     out  ADDR_W  burst start address, line aligned
//  arlen      out  8       constant BEATS-1
//  arvalid    out  1       AR valid
//  arready    in   1       AR accept
//  rdata      in   DATA_W  R data
//  rvalid     in   1       R valid
//  rlast      in   1       R last
//  rready     out  1       R ready
//  err        out  1       sticky protocol error flag
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE, all outputs 0, beat counter 0, rr pointer = I-side first, err=0.
//  States: IDLE -> ADDR -> DATA -> DONE -> IDLE.
//   IDLE: if any req, pick winner (rr), latch winner id and line address, go to ADDR next cycle.
//   ADDR: arvalid=1, araddr=latched; stay until arready=1, then go to DATA. Address stable while waiting.
//   DATA: rready=1. Each rvalid beat: winner's *_ready=1, *_rdata=rdata, *_beat=counter; counter++.
//         Beat with counter==BEATS-1 -> go to DONE.
//   DONE: winner's *_done=1 for one cycle; rr pointer flips to the other side; counter=0; go to IDLE.
//  Latency: req to arvalid = 1 cycle; min 1 line = 2+BEATS+1 cycles; IDLE re-arbitrates next cycle.
//  Arbitration: both reqs in the same IDLE cycle -> side != last granted wins; single req always wins.
//  Non-granted side: *_ready and *_done stay 0, rdata outputs 0.
//  Req dropped mid-burst: burst still completes; beats/done still strobed to that side.
//  rlast check: rlast=1 on a beat with counter!=BEATS-1, or rlast=0 on the final beat -> err=1 (sticky until reset).
//   Beat counting continues regardless.
//  Counter wraps modulo BEATS, cleared in DONE.
//  Reset asserted mid-burst: immediate return to IDLE, AR/R outputs dropped; any in-flight AXI beats are
//   the system's concern (global reset).
// CONFIGURATION
//  L1_REFILL_ARB_PERF_EN defined: adds outputs ic_grants, dc_grants, stall_cycles (32b each, reset 0).
//   *_grants increments on ADDR entry for that side.
//   stall_cycles increments every cycle a req is pending but not granted.
//  Not defined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  Package l1_refill_pkg: state enum {IDLE, ADDR, DATA, DONE}, BEATS, side id (SIDE_I=0, SIDE_D=1).
//  Sub-module rr_arb2: 2-input round-robin picker (req[1:0], last -> gnt[1:0]), combinational.
// TESTING
//  ic_req only, addr 0x0000_1234, arready same cycle, 4 rvalid back-to-back
//   -> araddr 0x0000_1230, arlen 3, ic_ready x4 beats 0..3, ic_done once.
//  ic_req and dc_req rise together after reset
//   -> I-side served first, then D-side; next simultaneous pair -> I again.
//  arready held 0 for 5 cycles
//   -> arvalid/araddr stable 5 cycles, no rready before accept.
//  rvalid gaps (1,0,0,1,1,0,1) -> exactly 4 ready strobes, beat index monotonic 0..3.
//  rlast on beat 1 -> err=1 and stays 1; burst still ends after beat 3.
//  rst_n low during DATA beat 2 -> all outputs 0 within the same cycle; fresh request after release starts at beat 0.

Source files
------------

// File: rtl/l1_refill_pkg.sv
// l1_refill_pkg: shared FSM states, line geometry and requester ids for the L1 refill arbiter.
package l1_refill_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  localparam int BEATS = 4;
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;
endpackage

// File: rtl/l1_refill_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin picker; on contention the side that was not granted last wins.
module rr_arb2
  import l1_refill_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~req[1] | last == SIDE_D);
  assign gnt[1] = req[1] & (~req[0] | last == SIDE_I);
endmodule

// File: rtl/l1_refill_arbiter.sv
// l1_refill_arbiter: shares one AXI read port between I- and D-cache line refills, one burst per grant.
// Define L1_REFILL_ARB_PERF_EN to add grant and stall performance counters.
module l1_refill_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ic_req,
  input  logic [ADDR_W-1:0]          ic_addr,
  output logic [DATA_W-1:0]          ic_rdata,
  output logic                       ic_ready,
  output logic [$clog2(BEATS)-1:0]   ic_beat,
  output logic                       ic_done,
  input  logic                       dc_req,
  input  logic [ADDR_W-1:0]          dc_addr,
  output logic [DATA_W-1:0]          dc_rdata,
  output logic                       dc_ready,
  output logic [$clog2(BEATS)-1:0]   dc_beat,
  output logic                       dc_done,
  output logic [ADDR_W-1:0]          araddr,
  output logic [7:0]                 arlen,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [DATA_W-1:0]          rdata,
  input  logic                       rvalid,
  input  logic                       rlast,
  output logic                       rready,
  output logic                       err
`ifdef L1_REFILL_ARB_PERF_EN
  ,
  output logic [31:0]                ic_grants,
  output logic [31:0]                dc_grants,
  output logic [31:0]                stall_cycles
`endif
);
  import l1_refill_pkg::*;
  localparam int CW = $clog2(BEATS);
  state_t state, state_n;
  logic win, last, beat, fin;
  logic [ADDR_W-1:0] addr_q;
  logic [CW-1:0] cnt;
  logic [1:0] gnt;
  rr_arb2 u_arb (.req({dc_req, ic_req}), .last(last), .gnt(gnt));
  assign beat = state == DATA && rvalid;
  assign fin  = beat && cnt == CW'(BEATS - 1);
  always_comb begin
    state_n = state == IDLE ? (|gnt ? ADDR : IDLE)
            : state == ADDR ? (arready ? DATA : ADDR)
            : state == DATA ? (fin ? DONE : DATA)
            : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win    <= SIDE_I;
      last   <= SIDE_D;
      addr_q <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      if (state == IDLE && |gnt) begin
        win    <= gnt[1];
        addr_q <= (gnt[1] ? dc_addr : ic_addr) & ~ADDR_W'(BEATS * DATA_W / 8 - 1);
      end
      if (beat) cnt <= cnt + CW'(1);
      // rlast must coincide exactly with the final counted beat
      if (beat && rlast != fin) err <= 1'b1;
      if (state == DONE) begin
        cnt  <= '0;
        last <= win;
      end
    end
  end
  assign arvalid  = state == ADDR;
  assign araddr   = arvalid ? addr_q : '0;
  assign arlen    = 8'(BEATS - 1);
  assign rready   = state == DATA;
  assign ic_ready = beat && win == SIDE_I;
  assign dc_ready = beat && win == SIDE_D;
  assign ic_rdata = ic_ready ? rdata : '0;
  assign dc_rdata = dc_ready ? rdata : '0;
  assign ic_beat  = ic_ready ? cnt : '0;
  assign dc_beat  = dc_ready ? cnt : '0;
  assign ic_done  = state == DONE && win == SIDE_I;
  assign dc_done  = state == DONE && win == SIDE_D;
`ifdef L1_REFILL_ARB_PERF_EN
  logic own_i, own_d, stall;
  assign own_i = state == IDLE ? gnt[0] : win == SIDE_I;
  assign own_d = state == IDLE ? gnt[1] : win == SIDE_D;
  assign stall = (ic_req & ~own_i) | (dc_req & ~own_d);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_grants    <= '0;
      dc_grants    <= '0;
      stall_cycles <= '0;
    end else begin
      if (state == IDLE && gnt[0]) ic_grants <= ic_grants + 32'd1;
      if (state == IDLE && gnt[1]) dc_grants <= dc_grants + 32'd1;
      if (stall) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_l1_refill_arbiter.sv
// tb_l1_refill_arbiter: directed AXI-slave stimulus with a queue-based scoreboard and negedge monitor.
module tb_l1_refill_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ic_req = 0, dc_req = 0, ic_ready, dc_ready, ic_done, dc_done;
  logic [31:0] ic_addr = 0, dc_addr = 0, ic_rdata, dc_rdata, araddr, rdata = 0;
  logic [1:0] ic_beat, dc_beat;
  logic [7:0] arlen;
  logic arvalid, arready = 0, rvalid = 0, rlast = 0, rready, err;
`ifdef L1_REFILL_ARB_PERF_EN
  logic [31:0] ic_grants, dc_grants, stall_cycles;
`endif
  int checks = 0, failures = 0;
  typedef struct packed {logic side; logic [1:0] beat; logic [31:0] data;} beat_t;
  beat_t beat_q[$];
  logic [31:0] ar_q[$];
  logic done_q[$];

  l1_refill_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
    .ic_beat(ic_beat), .ic_done(ic_done),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_rdata(dc_rdata), .dc_ready(dc_ready),
    .dc_beat(dc_beat), .dc_done(dc_done),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready), .err(err)
`ifdef L1_REFILL_ARB_PERF_EN
    , .ic_grants(ic_grants), .dc_grants(dc_grants), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctrl"}, {arvalid, rready, ic_ready, dc_ready, ic_done, dc_done, err, ic_beat, dc_beat}, 0);
    chk({name, "_araddr"}, araddr, 0);
    chk({name, "_rdata"}, {ic_rdata, dc_rdata}, 0);
  endtask

  task automatic mon_ar();
    logic [31:0] a;
    if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
    else begin
      a = ar_q.pop_front();
      chk("ar_addr_len", {araddr, arlen}, {a, 8'd3});
    end
  endtask

  task automatic mon_beat(input logic side, input logic [1:0] b, input logic [31:0] d, input logic other);
    beat_t e;
    if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
    else begin
      e = beat_q.pop_front();
      chk("beat_side_idx_data", {side, b, d}, e);
    end
    chk("other_side_quiet", other, 0);
  endtask

  task automatic mon_done(input logic side, input logic other);
    logic e;
    if (done_q.size() == 0) chk("done_unexpected", 1, 0);
    else begin
      e = done_q.pop_front();
      chk("done_side", side, e);
    end
    chk("done_exclusive", other, 0);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (arvalid && arready) mon_ar();
    if (ic_ready) mon_beat(1'b0, ic_beat, ic_rdata, dc_ready | dc_done | (|dc_rdata) | (|dc_beat));
    if (dc_ready) mon_beat(1'b1, dc_beat, dc_rdata, ic_ready | ic_done | (|ic_rdata) | (|ic_beat));
    if (ic_done) mon_done(1'b0, dc_done | ic_ready | dc_ready);
    if (dc_done) mon_done(1'b1, ic_done | ic_ready | dc_ready);
  end

  // Acts as the AXI slave for one burst and queues what the monitor should see.
  task automatic serve(input logic side, input logic [31:0] addr, input int ar_delay,
                       input logic [7:0] pat, input int plen, input int bad,
                       input logic [31:0] base, output int wait_n);
    int n = 0, b = 0, k = 0;
    logic v;
    ar_q.push_back(addr);
    done_q.push_back(side);
    while (!arvalid && n < 20) begin tick(); n++; end
    wait_n = n;
    if (!arvalid) begin
      chk("arvalid_timeout", 0, 1);
      return;
    end
    for (int i = 0; i < ar_delay; i++) begin
      arready = 0;
      @(negedge clk);
      chk("ar_hold_stable", {arvalid, rready, araddr}, {1'b1, 1'b0, addr});
      tick();
    end
    arready = 1;
    tick();
    arready = 0;
    while (b < 4 && k < 40) begin
      v = k < plen ? pat[k] : 1'b1;
      k++;
      rvalid = v;
      rdata = base + 32'(b);
      rlast = v && ((b == 3) != (b == bad));
      if (v) begin
        beat_q.push_back({side, 2'(b), base + 32'(b)});
        b++;
      end
      tick();
    end
    rvalid = 0;
    rlast = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    tick();
    rst_n = 1;
    tick();
    // single I request, immediate arready, back-to-back beats
    ic_addr = 32'h0000_1234;
    ic_req = 1;
    serve(1'b0, 32'h0000_1230, 0, 8'h00, 0, -1, 32'hA000_0000, n);
    chk("req_to_arvalid_latency", n, 1);
    ic_req = 0;
    tick(); tick();
    chk("err_clean", err, 0);
    // simultaneous requests from reset: I then D, then I again
    rst_n = 0; tick(); rst_n = 1; tick();
    ic_addr = 32'h0000_0100; dc_addr = 32'h0000_2008;
    ic_req = 1; dc_req = 1;
    serve(1'b0, 32'h0000_0100, 0, 8'h00, 0, -1, 32'hB000_0000, n);
    ic_req = 0;
    serve(1'b1, 32'h0000_2000, 0, 8'h00, 0, -1, 32'hC000_0000, n);
    dc_req = 0;
    tick();
    ic_addr = 32'h0000_300C; dc_addr = 32'h0000_3010;
    ic_req = 1; dc_req = 1;
    serve(1'b0, 32'h0000_3000, 0, 8'h00, 0, -1, 32'hD000_0000, n);
    ic_req = 0;
    // D waits on arready for 5 cycles
    serve(1'b1, 32'h0000_3010, 5, 8'h00, 0, -1, 32'hE000_0000, n);
    dc_req = 0;
    tick();
    // rvalid gaps 1,0,0,1,1,0,1
    ic_addr = 32'h0000_4004;
    ic_req = 1;
    serve(1'b0, 32'h0000_4000, 0, 8'h59, 7, -1, 32'h1111_0000, n);
    ic_req = 0;
    tick();
    chk("err_still_clean", err, 0);
    // early rlast on beat 1
    dc_addr = 32'h0000_5000;
    dc_req = 1;
    serve(1'b1, 32'h0000_5000, 0, 8'h00, 0, 1, 32'h2222_0000, n);
    dc_req = 0;
    tick();
    chk("err_set", err, 1);
    tick(); tick(); tick();
    chk("err_sticky", err, 1);
    // reset during DATA beat 2
    ic_addr = 32'h0000_6000;
    ic_req = 1;
    ar_q.push_back(32'h0000_6000);
    n = 0;
    while (!arvalid && n < 20) begin tick(); n++; end
    chk("abort_arvalid_seen", arvalid, 1);
    arready = 1; tick(); arready = 0;
    for (int b = 0; b < 2; b++) begin
      rvalid = 1; rdata = 32'h3333_0000 + 32'(b); rlast = 0;
      beat_q.push_back({1'b0, 2'(b), 32'h3333_0000 + 32'(b)});
      tick();
    end
    rvalid = 1; rdata = 32'h3333_0002;
    #2 rst_n = 0;
    @(negedge clk);
    check_zero("midburst_reset");
    rvalid = 0;
    tick();
    rst_n = 1;
    serve(1'b0, 32'h0000_6000, 0, 8'h00, 0, -1, 32'h4444_0000, n);
    ic_req = 0;
    tick(); tick();
    chk("err_cleared_by_reset", err, 0);
    chk("ar_queue_drained", ar_q.size(), 0);
    chk("beat_queue_drained", beat_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
